// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared encodings, vectors and IF/ID record for the fetch stage.
package if_stage_pkg;

    localparam logic [2:0] PCSRC_SEQ = 3'b000;
    localparam logic [2:0] PCSRC_J   = 3'b010;
    localparam logic [2:0] PCSRC_JR  = 3'b011;
    localparam logic [2:0] PCSRC_IRQ = 3'b100;
    localparam logic [2:0] PCSRC_EXC = 3'b101;

    localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
    localparam logic [31:0] ILLOP        = 32'h8000_0004;
    localparam logic [31:0] XADR         = 32'h8000_0008;
    localparam logic [31:0] NOP          = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;

    localparam ifid_t IFID_RESET = '{instr: NOP, pc_plus4: RESET_VECTOR, valid: 1'b0};

    // Bit 31 is the kernel bit; the increment may wrap bits 30:0 but never touches it.
    function automatic logic [31:0] seq_pc_of(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

    function automatic logic is_redirect(input logic [2:0] sel);
        return sel == PCSRC_J || sel == PCSRC_JR || sel == PCSRC_IRQ || sel == PCSRC_EXC;
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: combinational next-PC priority select and IF/ID flush decision.
module pc_next_mux
    import if_stage_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [25:0] j_index_i,
    input  logic [3:0]  j_region_i,
    input  logic [2:0]  pcsrc_i,
    input  logic [31:0] jr_target_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        stall_i,
    output logic [31:0] next_pc_o,
    output logic [31:0] seq_pc_o,
    output logic        flush_o
);
    logic [31:0] j_pc, jr_pc, sel_pc;

    assign seq_pc_o = seq_pc_of(pc_i);
    assign j_pc     = {j_region_i, j_index_i, 2'b00};
    // User code cannot enter kernel space through jr; only a kernel PC may keep bit 31.
    assign jr_pc    = {pc_i[31] & jr_target_i[31], jr_target_i[30:0]};

    always_comb begin
        sel_pc = pcsrc_i == PCSRC_IRQ ? ILLOP :
                 pcsrc_i == PCSRC_EXC ? XADR :
                 pcsrc_i == PCSRC_J   ? j_pc :
                 pcsrc_i == PCSRC_JR  ? jr_pc : seq_pc_o;
        next_pc_o = br_taken_i ? br_target_i : stall_i ? pc_i : sel_pc;
    end

    assign flush_o = br_taken_i | (~stall_i & is_redirect(pcsrc_i));

endmodule

// File: rtl/if_stage.sv
// if_stage: PC register, IF/ID pipeline register and pending-interrupt latch.
// Define IF_IRQ_SYNC_EN to pass irq_in through a two-flop synchronizer first.
module if_stage
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic [2:0]  pcsrc,
    input  logic [31:0] jr_target,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        stall,
    input  logic        irq_in,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic        irq_to_id
);
    logic [31:0] pc_q, pc_d, seq_pc;
    logic        flush, irq_src, pend_q, pend_d;
    ifid_t       ifid_q, ifid_d;

    pc_next_mux u_pc_next_mux (
        .pc_i        (pc_q),
        .j_index_i   (ifid_q.instr[25:0]),
        .j_region_i  (ifid_q.pc_plus4[31:28]),
        .pcsrc_i     (pcsrc),
        .jr_target_i (jr_target),
        .br_taken_i  (br_taken),
        .br_target_i (br_target),
        .stall_i     (stall),
        .next_pc_o   (pc_d),
        .seq_pc_o    (seq_pc),
        .flush_o     (flush)
    );

`ifdef IF_IRQ_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge reset)
        if (!reset) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], irq_in};
    assign irq_src = sync_q[1];
`else
    assign irq_src = irq_in;
`endif

    // A flush keeps pc_plus4 so a later j still sees the region of the squashed slot.
    always_comb begin
        ifid_d = ifid_q;
        if (flush) begin
            ifid_d.instr = NOP;
            ifid_d.valid = 1'b0;
        end else if (!stall) begin
            ifid_d = '{instr: imem_data, pc_plus4: seq_pc, valid: 1'b1};
        end
    end

    assign pend_d = (pcsrc == PCSRC_IRQ && !stall) ? 1'b0 : pend_q | irq_src;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            pc_q   <= RESET_VECTOR;
            ifid_q <= IFID_RESET;
            pend_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
            pend_q <= pend_d;
        end

    assign imem_addr     = pc_q;
    assign ifid_instr    = ifid_q.instr;
    assign ifid_pc_plus4 = ifid_q.pc_plus4;
    assign ifid_valid    = ifid_q.valid;
    // Masked during stall so a held instruction never presents the request twice.
    assign irq_to_id     = pend_q & ifid_q.valid & ~ifid_q.pc_plus4[31] & ~stall;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed vector table, hand sequences and randomized model check for if_stage.
module tb_if_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr, imem_data, jr_target, br_target;
    logic [31:0] ifid_instr, ifid_pc_plus4;
    logic [2:0]  pcsrc;
    logic        br_taken, stall, irq_in, ifid_valid, irq_to_id;

    int checks = 0;
    int errors = 0;

    if_stage dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .pcsrc(pcsrc), .jr_target(jr_target), .br_taken(br_taken), .br_target(br_target),
        .stall(stall), .irq_in(irq_in), .ifid_instr(ifid_instr),
        .ifid_pc_plus4(ifid_pc_plus4), .ifid_valid(ifid_valid), .irq_to_id(irq_to_id)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a == 32'h0000_0100) ? 32'h0800_0010 : (a ^ 32'h5A5A_1234) + 32'h11;
    endfunction

    assign imem_data = rom(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pp4;
    logic        m_valid, m_pend;
    logic [1:0]  m_sync;

    task automatic model_reset();
        m_pc = 32'h8000_0000; m_instr = 0; m_pp4 = 32'h8000_0000;
        m_valid = 0; m_pend = 0; m_sync = 0;
    endtask

    // Applies one rising edge with the inputs currently driven.
    task automatic model_edge();
        logic [31:0] seqp, npc;
        logic        src;
        seqp = (m_pc & 32'h8000_0000) | ((m_pc + 32'd4) & 32'h7FFF_FFFF);
`ifdef IF_IRQ_SYNC_EN
        src = m_sync[1];
        m_sync = {m_sync[0], irq_in};
`else
        src = irq_in;
`endif
        m_pend = (pcsrc == 3'd4 && !stall) ? 1'b0 : (m_pend | src);
        if (br_taken) begin
            m_pc = br_target; m_instr = 0; m_valid = 0;
        end else if (!stall) begin
            case (pcsrc)
                3'd4: npc = 32'h8000_0004;
                3'd5: npc = 32'h8000_0008;
                3'd2: npc = {m_pp4[31:28], m_instr[25:0], 2'b00};
                3'd3: npc = {m_pc[31] & jr_target[31], jr_target[30:0]};
                default: npc = seqp;
            endcase
            if (pcsrc inside {3'd2, 3'd3, 3'd4, 3'd5}) begin
                m_instr = 0; m_valid = 0;
            end else begin
                m_instr = rom(m_pc); m_pp4 = seqp; m_valid = 1;
            end
            m_pc = npc;
        end
    endtask

    task automatic model_check(input string tag);
        chk({tag, " pc"}, imem_addr, m_pc);
        chk({tag, " instr"}, ifid_instr, m_instr);
        chk({tag, " pp4"}, ifid_pc_plus4, m_pp4);
        chk({tag, " valid"}, {31'd0, ifid_valid}, {31'd0, m_valid});
        chk({tag, " irq"}, {31'd0, irq_to_id}, {31'd0, m_pend & m_valid & ~m_pp4[31] & ~stall});
    endtask

    task automatic do_reset();
        reset = 0; stall = 0; br_taken = 0; pcsrc = 0; jr_target = 0; br_target = 0; irq_in = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
        model_reset();
    endtask

    task automatic step(input logic s, input logic b, input logic [2:0] p,
                        input logic [31:0] j, input logic [31:0] bt, input logic irq);
        stall = s; br_taken = b; pcsrc = p; jr_target = j; br_target = bt; irq_in = irq;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        stall, br;
        logic [2:0]  pcsrc;
        logic [31:0] jr, brt, e_pc, e_instr, e_pp4;
        logic        e_valid;
    } vec_t;

    vec_t tbl[21];

    initial begin
        tbl[0]  = '{0, 0, 3'd0, 0, 0, 32'h8000_0004, rom(32'h8000_0000), 32'h8000_0004, 1};
        tbl[1]  = '{0, 0, 3'd0, 0, 0, 32'h8000_0008, rom(32'h8000_0004), 32'h8000_0008, 1};
        tbl[2]  = '{1, 0, 3'd0, 0, 0, 32'h8000_0008, rom(32'h8000_0004), 32'h8000_0008, 1};
        tbl[3]  = tbl[2];
        tbl[4]  = tbl[2];
        tbl[5]  = '{1, 1, 3'd0, 0, 32'h0000_0300, 32'h0000_0300, 0, 32'h8000_0008, 0};
        tbl[6]  = '{0, 0, 3'd0, 0, 0, 32'h0000_0304, rom(32'h0000_0300), 32'h0000_0304, 1};
        tbl[7]  = '{0, 0, 3'd3, 32'h8000_1000, 0, 32'h0000_1000, 0, 32'h0000_0304, 0};
        tbl[8]  = '{0, 0, 3'd0, 0, 0, 32'h0000_1004, rom(32'h0000_1000), 32'h0000_1004, 1};
        tbl[9]  = '{0, 0, 3'd5, 0, 0, 32'h8000_0008, 0, 32'h0000_1004, 0};
        tbl[10] = '{0, 0, 3'd3, 32'h8000_1000, 0, 32'h8000_1000, 0, 32'h0000_1004, 0};
        tbl[11] = '{0, 0, 3'd3, 32'h0000_0100, 0, 32'h0000_0100, 0, 32'h0000_1004, 0};
        tbl[12] = '{0, 0, 3'd0, 0, 0, 32'h0000_0104, 32'h0800_0010, 32'h0000_0104, 1};
        tbl[13] = '{0, 0, 3'd2, 0, 0, 32'h0000_0040, 0, 32'h0000_0104, 0};
        tbl[14] = '{0, 0, 3'd7, 0, 0, 32'h0000_0044, rom(32'h0000_0040), 32'h0000_0044, 1};
        tbl[15] = '{0, 0, 3'd4, 0, 0, 32'h8000_0004, 0, 32'h0000_0044, 0};
        tbl[16] = '{1, 0, 3'd2, 0, 0, 32'h8000_0004, 0, 32'h0000_0044, 0};
        tbl[17] = '{0, 1, 3'd0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 32'h0000_0044, 0};
        tbl[18] = '{0, 0, 3'd0, 0, 0, 32'h8000_0000, rom(32'hFFFF_FFFC), 32'h8000_0000, 1};
        tbl[19] = '{0, 1, 3'd0, 0, 32'h7FFF_FFFC, 32'h7FFF_FFFC, 0, 32'h8000_0000, 0};
        tbl[20] = '{0, 0, 3'd0, 0, 0, 32'h0000_0000, rom(32'h7FFF_FFFC), 32'h0000_0000, 1};

        do_reset();
        chk("reset pc", imem_addr, 32'h8000_0000);
        chk("reset instr", ifid_instr, 32'h0);
        chk("reset pp4", ifid_pc_plus4, 32'h8000_0000);
        chk("reset valid", {31'd0, ifid_valid}, 32'd0);
        chk("reset irq", {31'd0, irq_to_id}, 32'd0);

        foreach (tbl[i]) begin
            step(tbl[i].stall, tbl[i].br, tbl[i].pcsrc, tbl[i].jr, tbl[i].brt, 1'b0);
            chk($sformatf("row%0d pc", i), imem_addr, tbl[i].e_pc);
            chk($sformatf("row%0d instr", i), ifid_instr, tbl[i].e_instr);
            chk($sformatf("row%0d pp4", i), ifid_pc_plus4, tbl[i].e_pp4);
            chk($sformatf("row%0d valid", i), {31'd0, ifid_valid}, {31'd0, tbl[i].e_valid});
            chk($sformatf("row%0d irq", i), {31'd0, irq_to_id}, 32'd0);
        end

        // Interrupt held off in kernel mode and on bubbles, then taken from user code.
        do_reset();
        repeat (4) step(0, 0, 3'd0, 0, 0, 1'b1);
        chk("irq kmode pp4", ifid_pc_plus4, 32'h8000_0010);
        chk("irq kmode", {31'd0, irq_to_id}, 32'd0);
        step(0, 0, 3'd3, 32'h0000_0100, 0, 1'b0);
        chk("irq bubble", {31'd0, irq_to_id}, 32'd0);
        step(0, 0, 3'd0, 0, 0, 1'b0);
        chk("irq user pp4", ifid_pc_plus4, 32'h0000_0104);
        chk("irq user", {31'd0, irq_to_id}, 32'd1);
        step(1, 0, 3'd0, 0, 0, 1'b0);
        chk("irq stall mask", {31'd0, irq_to_id}, 32'd0);
        step(0, 0, 3'd4, 0, 0, 1'b0);
        chk("irq accept pc", imem_addr, 32'h8000_0004);
        step(0, 0, 3'd3, 32'h0000_0100, 0, 1'b0);
        step(0, 0, 3'd0, 0, 0, 1'b0);
        chk("irq cleared", {31'd0, irq_to_id}, 32'd0);

        // Asynchronous reset during a stall.
        step(0, 1, 3'd0, 0, 32'h0000_0400, 1'b0);
        step(1, 0, 3'd0, 0, 0, 1'b0);
        chk("stall pc", imem_addr, 32'h0000_0400);
        #2 reset = 0;
        #1;
        chk("async rst pc", imem_addr, 32'h8000_0000);
        chk("async rst valid", {31'd0, ifid_valid}, 32'd0);
        chk("async rst instr", ifid_instr, 32'h0);

        // Randomized run against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            stall     = ($urandom_range(0, 4) == 0);
            br_taken  = ($urandom_range(0, 9) == 0);
            br_target = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, 21'd0, 8'($urandom), 2'b00};
            jr_target = $urandom;
            irq_in    = ($urandom_range(0, 7) == 0);
            pcsrc     = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            if ((m_pend & m_valid & ~m_pp4[31] & ~stall) && $urandom_range(0, 1) == 1) pcsrc = 3'd4;
            @(posedge clk);
            model_edge();
            #1;
            model_check($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately.
REQ-003 SHALL have ports: imem_addr  out  32  fetch PC to combinational instruction ROM; imem_data  in  32  fetched word, same cycle.
REQ-004 SHALL have ports: pcsrc  in  3  next-PC select from ID decoder (000 seq, 010 j/jal, 011 jr/jalr, 100 irq, 101 exception).
REQ-005 SHALL have ports: jr_target  in  32  forwarded rs value for jr/jalr.
REQ-006 SHALL have ports: br_taken  in  1  EX branch resolved taken; br_target  in  32  EX branch target.
REQ-007 SHALL have ports: stall  in  1  load-use hold from hazard unit.
REQ-008 SHALL have ports: irq_in  in  1  external interrupt request.
REQ-009 SHALL have ports: ifid_instr  out  32; ifid_pc_plus4  out  32; ifid_valid  out  1; irq_to_id  out  1  (feeds decoder IRQ input).

Function
REQ-010 SHALL hold PC register; imem_addr = PC combinationally.
REQ-011 SHALL compute seq PC as {PC[31], PC[30:0]+4}; bit 31 (kernel bit) never changed by increment, wrap of bits 30:0 allowed.
REQ-012 SHALL select next PC by priority: br_taken -> br_target; else stall -> hold PC; else pcsrc 100 -> 0x8000_0004; 101 -> 0x8000_0008; 010 -> {ifid_pc_plus4[31:28], ifid_instr[25:0], 2'b00}; 011 -> {PC[31] & jr_target[31], jr_target[30:0]}; 000 -> seq PC; other codes -> seq PC.
REQ-013 SHALL load IF/ID with {imem_data, seq PC, valid=1} on each non-stall, non-flush edge.
REQ-014 SHALL hold IF/ID unchanged while stall=1 and br_taken=0.
REQ-015 SHALL flush IF/ID (instr=0x0000_0000, pc_plus4 unchanged, valid=0) when br_taken=1, or when stall=0 and pcsrc is 010/011/100/101.
REQ-016 br_taken and stall simultaneous: br_taken wins; PC<-br_target, IF/ID flushed.
REQ-017 SHALL raise irq_to_id only when irq request is pending, ifid_valid=1 and ifid_pc_plus4[31]=0; never in kernel mode or on a bubble.
REQ-018 SHALL hold irq_to_id at 0 during stall=1 so the decoder never sees it on a held instruction twice.
REQ-019 SHALL latch pending irq (level) until accepted (pcsrc=100 with stall=0); cleared on acceptance edge.
REQ-020 Latency: fetched word visible on ifid_instr one cycle after its PC appears on imem_addr.

Reset
REQ-021 SHALL on reset=0 set PC=0x8000_0000, ifid_instr=0, ifid_pc_plus4=0x8000_0000, ifid_valid=0, irq pending=0, synchronizer flops=0.
REQ-022 SHALL, if reset asserts mid-operation (incl. during stall or flush), discard in-flight state with no partial update.
REQ-023 First fetch after reset release SHALL be from 0x8000_0000 on the first rising edge.

Configuration
REQ-024 Macro IF_IRQ_SYNC_EN: defined -> irq_in passes two-flop synchronizer before pending latch (2 extra cycles latency); undefined -> irq_in sampled directly into pending latch.

Structure
REQ-025 Shared package SHALL hold pcsrc encodings, RESET_VECTOR 0x8000_0000, ILLOP 0x8000_0004, XADR 0x8000_0008, NOP 0x0000_0000.
REQ-026 One sub-module natural: pc_next_mux (combinational next-PC priority select); registers stay in if_stage.

Verification
REQ-027 Reset release, pcsrc=000, no stall -> imem_addr 0x8000_0000, 0x8000_0004, 0x8000_0008 on successive cycles; ifid_valid=1 from cycle 1.
REQ-028 ifid_instr=0x0800_0010 (j), pcsrc=010, ifid_pc_plus4=0x0000_0104 -> next PC 0x0000_0040, IF/ID bubble (instr 0, valid 0).
REQ-029 User mode PC=0x0000_0200, pcsrc=011, jr_target=0x8000_1000 -> next PC 0x0000_1000 (kernel bit blocked); kernel mode same -> 0x8000_1000.
REQ-030 stall=1 and br_taken=1, br_target=0x0000_0300 same cycle -> PC 0x0000_0300, IF/ID flushed; stall=1 alone -> PC and IF/ID held 3 cycles.
REQ-031 irq_in=1 while ifid_pc_plus4=0x8000_0010 -> irq_to_id stays 0; after jump to user PC 0x0000_0100 -> irq_to_id=1, pcsrc=100 -> PC 0x8000_0004, pending cleared.
REQ-032 reset pulsed low during stall with PC=0x0000_0400 -> PC 0x8000_0000 immediately, ifid_valid=0.
